// File: rtl/bin2rns_seq_hs.sv
// Bit-serial binary-to-RNS forward converter for {2^k, m2, m3, m4} with a
// valid/ready handshake on both sides and an out-of-dynamic-range flag.
//
// state | meaning
// IDLE  | waiting for an operand, in_ready high
// RUN   | one operand bit per cycle folded into r2/r3/r4, MSB first
// DONE  | residues presented, out_valid high until out_ready
module bin2rns_seq_hs #(
  parameter int DYN_SIZE = 17,
  parameter int MAX_MOD  = 5,
  parameter int MOD_1_K  = 5,
  parameter int MOD_2    = 31,
  parameter int MOD_3    = 21,
  parameter int MOD_4    = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DYN_SIZE:0]   N,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [MAX_MOD-1:0]  x0,
  output logic [MAX_MOD-1:0]  x1,
  output logic [MAX_MOD-1:0]  x2,
  output logic [MAX_MOD-1:0]  x3,
  output logic                out_ovf
);

  localparam int CW = $clog2(DYN_SIZE + 2);
  // Wide enough for the full product of the four moduli.
  localparam int MW = MOD_1_K + 3 * MAX_MOD + DYN_SIZE + 2;
  localparam logic [MW-1:0] M = (MW'(1) << MOD_1_K) * MW'(MOD_2) * MW'(MOD_3) * MW'(MOD_4);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t              state, state_nxt;
  logic [DYN_SIZE:0]   sh;
  logic [CW-1:0]       cnt;
  logic [MAX_MOD-1:0]  r2, r3, r4;
  logic [MAX_MOD-1:0]  x0_q;
  logic                ovf_q;
  logic                accept;
  logic                last_bit;
  logic                b;

  // r < m, so 2r + b < 2m and one conditional subtraction reduces it.
  function automatic logic [MAX_MOD-1:0] mod_step(input logic [MAX_MOD-1:0] r,
                                                  input logic b_in,
                                                  input logic [MAX_MOD:0] m);
    logic [MAX_MOD:0] t;
    logic [MAX_MOD:0] d;
    t = {r, b_in};
    d = (t >= m) ? (t - m) : t;
    return d[MAX_MOD-1:0];
  endfunction

  assign accept   = (state == IDLE) && in_valid;
  assign last_bit = (cnt == CW'(DYN_SIZE));
  assign b        = sh[DYN_SIZE];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = RUN;
      RUN:     if (last_bit) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sh    <= '0;
      cnt   <= '0;
      r2    <= '0;
      r3    <= '0;
      r4    <= '0;
      x0_q  <= '0;
      ovf_q <= 1'b0;
    end else if (accept) begin
      sh    <= N;
      cnt   <= '0;
      r2    <= '0;
      r3    <= '0;
      r4    <= '0;
      x0_q  <= MAX_MOD'(N[MOD_1_K-1:0]);
      ovf_q <= (MW'(N) >= M);
    end else if (state == RUN) begin
      sh  <= {sh[DYN_SIZE-1:0], 1'b0};
      cnt <= cnt + CW'(1);
      r2  <= mod_step(r2, b, (MAX_MOD+1)'(MOD_2));
      r3  <= mod_step(r3, b, (MAX_MOD+1)'(MOD_3));
      r4  <= mod_step(r4, b, (MAX_MOD+1)'(MOD_4));
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign x0        = x0_q;
  assign x1        = r2;
  assign x2        = r3;
  assign x3        = r4;
  assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_bin2rns_seq_hs.sv
// Directed and strided-sweep bench for bin2rns_seq_hs with default parameters.
module tb_bin2rns_seq_hs;

  localparam int DYN_SIZE = 17;
  localparam int LAT      = DYN_SIZE + 1;
  localparam int M_DYN    = 32 * 31 * 21 * 5;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [17:0] N;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  x0, x1, x2, x3;
  logic        out_ovf;

  int checks;
  int errors;
  int accepts;
  int handshakes;

  bin2rns_seq_hs dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .N(N),
    .out_valid(out_valid), .out_ready(out_ready),
    .x0(x0), .x1(x1), .x2(x2), .x3(x3), .out_ovf(out_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; N = '0;
    #1;
    checks++;
    if ({in_ready, out_valid, x0, x1, x2, x3, out_ovf} !== {1'b1, 1'b0, 20'd0, 1'b0}) begin
      errors++;
      $display("FAIL reset_state: got rdy=%0b vld=%0b x=%0d,%0d,%0d,%0d ovf=%0b, want rdy=1 vld=0 x=0,0,0,0 ovf=0",
               in_ready, out_valid, x0, x1, x2, x3, out_ovf);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // One operand end to end; stall_pct randomises out_ready once out_valid is up.
  task automatic run_op(input logic [17:0] n, input logic [4:0] e0, input logic [4:0] e1,
                        input logic [4:0] e2, input logic [4:0] e3, input logic eo,
                        input string name, input int stall_pct);
    int cyc;
    int guard;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_idle: got rdy=%0b vld=%0b, want rdy=1 vld=0", name, in_ready, out_valid);
    end
    in_valid = 1'b1; N = n; out_ready = 1'b1;
    @(posedge clk);
    accepts++;
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s_busy: got in_ready=%0b, want 0", name, in_ready);
    end
    cyc = 0;
    while (out_valid !== 1'b1 && cyc < 40) begin
      @(posedge clk); @(negedge clk);
      cyc++;
    end
    checks++;
    if (cyc != LAT) begin
      errors++;
      $display("FAIL %s_latency: got %0d cycles, want %0d", name, cyc, LAT);
      return;
    end
    guard = 0;
    forever begin
      out_ready = ($urandom_range(0, 99) < stall_pct) ? 1'b0 : 1'b1;
      #1;
      checks++;
      if ({out_valid, in_ready, x0, x1, x2, x3, out_ovf} !== {1'b1, 1'b0, e0, e1, e2, e3, eo}) begin
        errors++;
        $display("FAIL %s_result: got vld=%0b rdy=%0b x=%0d,%0d,%0d,%0d ovf=%0b, want vld=1 rdy=0 x=%0d,%0d,%0d,%0d ovf=%0b",
                 name, out_valid, in_ready, x0, x1, x2, x3, out_ovf, e0, e1, e2, e3, eo);
        out_ready = 1'b1;
      end
      @(posedge clk);
      if (out_ready) handshakes++;
      @(negedge clk);
      if (out_ready) break;
      guard++;
      if (guard > 60) begin
        out_ready = 1'b1;
      end
    end
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_release: got rdy=%0b vld=%0b, want rdy=1 vld=0", name, in_ready, out_valid);
    end
  endtask

  task automatic test_directed();
    run_op(18'd0,      5'd0,  5'd0,  5'd0,  5'd0, 1'b0, "n_zero",   0);
    run_op(18'd65535,  5'd31, 5'd1,  5'd15, 5'd0, 1'b0, "n_65535",  0);
    run_op(18'd104159, 5'd31, 5'd30, 5'd20, 5'd4, 1'b0, "n_m_minus1", 0);
    run_op(18'd104160, 5'd0,  5'd0,  5'd0,  5'd0, 1'b1, "n_m",      0);
    run_op(18'd262143, 5'd31, 5'd7,  5'd0,  5'd3, 1'b1, "n_max",    0);
    run_op(18'd1234,   5'd18, 5'd25, 5'd16, 5'd4, 1'b0, "n_1234",   0);
  endtask

  task automatic test_backpressure();
    int cyc;
    @(negedge clk);
    in_valid = 1'b1; N = 18'd65535; out_ready = 1'b0;
    @(posedge clk);
    accepts++;
    @(negedge clk);
    N = 18'd104160;  // second operand offered and held from here on
    cyc = 0;
    while (out_valid !== 1'b1 && cyc < 40) begin
      @(posedge clk); @(negedge clk);
      cyc++;
    end
    checks++;
    if (cyc != LAT) begin
      errors++;
      $display("FAIL bp_latency: got %0d cycles, want %0d", cyc, LAT);
    end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if ({out_valid, in_ready, x0, x1, x2, x3, out_ovf} !== {1'b1, 1'b0, 5'd31, 5'd1, 5'd15, 5'd0, 1'b0}) begin
        errors++;
        $display("FAIL bp_hold[%0d]: got vld=%0b rdy=%0b x=%0d,%0d,%0d,%0d ovf=%0b, want vld=1 rdy=0 x=31,1,15,0 ovf=0",
                 i, out_valid, in_ready, x0, x1, x2, x3, out_ovf);
      end
      @(posedge clk); @(negedge clk);
    end
    out_ready = 1'b1;
    @(posedge clk);
    handshakes++;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_release: got rdy=%0b vld=%0b, want rdy=1 vld=0", in_ready, out_valid);
    end
    @(posedge clk);
    accepts++;
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_second_accept: got in_ready=%0b, want 0", in_ready);
    end
    cyc = 0;
    while (out_valid !== 1'b1 && cyc < 40) begin
      @(posedge clk); @(negedge clk);
      cyc++;
    end
    checks++;
    if (cyc != LAT || {x0, x1, x2, x3, out_ovf} !== {20'd0, 1'b1}) begin
      errors++;
      $display("FAIL bp_second: got lat=%0d x=%0d,%0d,%0d,%0d ovf=%0b, want lat=%0d x=0,0,0,0 ovf=1",
               cyc, x0, x1, x2, x3, out_ovf, LAT);
    end
    @(posedge clk);
    handshakes++;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_run();
    @(negedge clk);
    in_valid = 1'b1; N = 18'd1234; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    checks++;
    if (x0 !== 5'd18 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL midrst_pre: got x0=%0d rdy=%0b, want x0=18 rdy=0", x0, in_ready);
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({in_ready, out_valid, x0, x1, x2, x3, out_ovf} !== {1'b1, 1'b0, 20'd0, 1'b0}) begin
      errors++;
      $display("FAIL midrst_async: got rdy=%0b vld=%0b x=%0d,%0d,%0d,%0d ovf=%0b, want rdy=1 vld=0 x=0,0,0,0 ovf=0",
               in_ready, out_valid, x0, x1, x2, x3, out_ovf);
    end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL midrst_no_valid[%0d]: got out_valid=%0b, want 0", i, out_valid);
      end
    end
    run_op(18'd1234, 5'd18, 5'd25, 5'd16, 5'd4, 1'b0, "midrst_after", 0);
  endtask

  task automatic test_sweep();
    logic [17:0] n;
    int a0;
    int h0;
    a0 = accepts;
    h0 = handshakes;
    for (int i = 0; i < 1200; i++) begin
      n = 18'(i * 218 + (i % 7));
      run_op(n, 5'(n % 32), 5'(n % 31), 5'(n % 21), 5'(n % 5), (int'(n) >= M_DYN),
             "sweep", 30);
    end
    checks++;
    if ((handshakes - h0) != (accepts - a0) || (accepts - a0) != 1200) begin
      errors++;
      $display("FAIL sweep_count: got accepts=%0d handshakes=%0d, want 1200 each",
               accepts - a0, handshakes - h0);
    end
  endtask

  initial begin
    checks = 0; errors = 0; accepts = 0; handshakes = 0;
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid_run();
    test_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
